// File: rtl/alu_pkg.sv
// Shared op codes, FSM states and constants for the multi-cycle execute ALU.
package alu_pkg;

  localparam int AOPW_DEF = 6;
  localparam int XLEN_MAX = 128;

  typedef enum logic [AOPW_DEF-1:0] {
    OP_ADD    = 6'd0,
    OP_SLL    = 6'd1,
    OP_SLT    = 6'd2,
    OP_SLTU   = 6'd3,
    OP_XOR    = 6'd4,
    OP_SRL    = 6'd5,
    OP_OR     = 6'd6,
    OP_AND    = 6'd7,
    OP_SRA    = 6'd8,
    OP_SUB    = 6'd9,
    OP_MUL    = 6'd10,
    OP_MULH   = 6'd11,
    OP_MULHSU = 6'd12,
    OP_MULHU  = 6'd13,
    OP_DIV    = 6'd14,
    OP_DIVU   = 6'd15,
    OP_REM    = 6'd16,
    OP_REMU   = 6'd17
  } aluop_e;

  // Same order as OP_MUL..OP_REMU so the function is aluop - OP_MUL.
  typedef enum logic [2:0] {
    MD_MUL, MD_MULH, MD_MULHSU, MD_MULHU, MD_DIV, MD_DIVU, MD_REM, MD_REMU
  } md_fn_e;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  // Sliced to XLEN at the point of use.
  localparam logic [XLEN_MAX-1:0] DIV0_QUOT = '1;

endpackage

// File: rtl/alu_muldiv.sv
// Iterative multiply/divide: one product/quotient bit per cycle over operand magnitudes.
// Latency: start -> done_o in the XLEN-th busy cycle; result_o valid with done_o. kill_i aborts.
module alu_muldiv
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic            kill_i,
  input  md_fn_e          fn_i,
  input  logic [XLEN-1:0] op1_i,
  input  logic [XLEN-1:0] op2_i,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);
  localparam int CW = $clog2(XLEN);

  logic              busy_q;
  logic [CW-1:0]     cnt_q;
  logic [2*XLEN-1:0] acc_q, acc_nxt;
  logic [XLEN-1:0]   b_q;
  md_fn_e            fn_q;
  logic              is_div_q, neg_q;

  logic              a_neg, b_neg, is_div, neg;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic [XLEN:0]     sum, trial, diff;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   qr;

  always_comb begin
    a_neg  = (fn_i inside {MD_MUL, MD_MULH, MD_MULHSU, MD_DIV, MD_REM}) && op1_i[XLEN-1];
    b_neg  = (fn_i inside {MD_MUL, MD_MULH, MD_DIV, MD_REM}) && op2_i[XLEN-1];
    mag_a  = a_neg ? -op1_i : op1_i;
    mag_b  = b_neg ? -op2_i : op2_i;
    is_div = fn_i inside {MD_DIV, MD_DIVU, MD_REM, MD_REMU};
    // Remainder follows the dividend; everything else uses the product sign.
    neg    = (fn_i inside {MD_REM, MD_REMU}) ? a_neg : (a_neg ^ b_neg);
  end

  // acc_q = {high/remainder, low/multiplier-or-quotient}
  always_comb begin
    sum   = '0;
    trial = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    diff  = trial - {1'b0, b_q};
    if (is_div_q) begin
      if (!diff[XLEN]) acc_nxt = {diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
      else             acc_nxt = {trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
    end else begin
      sum     = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
      acc_nxt = {sum, acc_q[XLEN-1:1]};
    end
  end

  always_comb begin
    prod = neg_q ? -acc_nxt : acc_nxt;
    qr   = (fn_q inside {MD_REM, MD_REMU}) ? acc_nxt[2*XLEN-1:XLEN] : acc_nxt[XLEN-1:0];
    if (is_div_q)           result_o = neg_q ? -qr : qr;
    else if (fn_q == MD_MUL) result_o = prod[XLEN-1:0];
    else                    result_o = prod[2*XLEN-1:XLEN];
  end

  assign done_o = busy_q && (cnt_q == CW'(XLEN-1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      b_q      <= '0;
      fn_q     <= MD_MUL;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
    end else if (kill_i) begin
      busy_q <= 1'b0;
    end else if (start_i) begin
      busy_q   <= 1'b1;
      cnt_q    <= '0;
      acc_q    <= {{XLEN{1'b0}}, mag_a};
      b_q      <= mag_b;
      fn_q     <= fn_i;
      is_div_q <= is_div;
      neg_q    <= neg;
    end else if (busy_q) begin
      acc_q <= acc_nxt;
      cnt_q <= cnt_q + 1'b1;
      if (done_o) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Handshaked RV32 execute ALU; iterative M-extension built only with ALU_MULDIV_EN.
// Latency: base/undefined ops 1 cycle, MUL/DIV XLEN+1 cycles (div-by-zero/overflow 1 cycle).
// Backpressure: result held in DONE until ready_i; ready_o low while BUSY or stalled.
module alu_mc
  import alu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int AOPW = 6
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [XLEN-1:0] op1_i,
  input  logic [XLEN-1:0] op2_i,
  input  logic [AOPW-1:0] aluop_i,
  input  logic            kill_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [XLEN-1:0] alu_result_o,
  output logic            illegal_o
);
  localparam int SHW = $clog2(XLEN);

  state_e          state_q, state_d;
  logic [XLEN-1:0] res_q, res_d;
  logic            ill_q, ill_d;
  logic            accept, base_op, op_illegal, fast_op;
  logic [XLEN-1:0] base_res, fast_res;
  logic [SHW-1:0]  shamt;

  assign shamt   = op2_i[SHW-1:0];
  assign base_op = aluop_i <= AOPW'(OP_SUB);

  always_comb begin
    base_res = '0;
    case (aluop_i)
      AOPW'(OP_ADD):  base_res = op1_i + op2_i;
      AOPW'(OP_SLL):  base_res = op1_i << shamt;
      AOPW'(OP_SLT):  base_res = {{(XLEN-1){1'b0}}, $signed(op1_i) < $signed(op2_i)};
      AOPW'(OP_SLTU): base_res = {{(XLEN-1){1'b0}}, op1_i < op2_i};
      AOPW'(OP_XOR):  base_res = op1_i ^ op2_i;
      AOPW'(OP_SRL):  base_res = op1_i >> shamt;
      AOPW'(OP_OR):   base_res = op1_i | op2_i;
      AOPW'(OP_AND):  base_res = op1_i & op2_i;
      AOPW'(OP_SRA):  base_res = $signed(op1_i) >>> shamt;
      AOPW'(OP_SUB):  base_res = op1_i - op2_i;
      default:        base_res = '0;
    endcase
  end

`ifdef ALU_MULDIV_EN
  logic            md_op, md_div, md_rem, div_zero, div_ovf, md_start, md_done;
  md_fn_e          md_fn;
  logic [XLEN-1:0] md_res;

  assign md_op    = (aluop_i >= AOPW'(OP_MUL)) && (aluop_i <= AOPW'(OP_REMU));
  assign md_fn    = md_fn_e'(3'(aluop_i - AOPW'(OP_MUL)));
  assign md_div   = md_fn inside {MD_DIV, MD_DIVU, MD_REM, MD_REMU};
  assign md_rem   = md_fn inside {MD_REM, MD_REMU};
  assign div_zero = (op2_i == '0);
  assign div_ovf  = (md_fn inside {MD_DIV, MD_REM}) && (op1_i == {1'b1, {(XLEN-1){1'b0}}})
                    && (op2_i == '1);

  assign op_illegal = !(base_op || md_op);
  // Divide special cases resolve without iterating.
  assign fast_op    = !md_op || (md_div && (div_zero || div_ovf));

  always_comb begin
    fast_res = base_res;
    if (md_op) begin
      if (div_zero)    fast_res = md_rem ? op1_i : DIV0_QUOT[XLEN-1:0];
      else if (md_rem) fast_res = '0;
      else             fast_res = op1_i;
    end
  end

  assign ready_o = (state_q == IDLE) || ((state_q == DONE) && ready_i);

  alu_muldiv #(.XLEN(XLEN)) u_muldiv (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .start_i  (md_start),
    .kill_i   (kill_i),
    .fn_i     (md_fn),
    .op1_i    (op1_i),
    .op2_i    (op2_i),
    .done_o   (md_done),
    .result_o (md_res)
  );
`else
  assign op_illegal = !base_op;
  assign fast_op    = 1'b1;
  assign fast_res   = base_res;
  assign ready_o    = (state_q == IDLE) || ready_i;
`endif

  assign accept = valid_i && ready_o && !kill_i;

  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    ill_d   = ill_q;
`ifdef ALU_MULDIV_EN
    md_start = 1'b0;
`endif
    case (state_q)
`ifdef ALU_MULDIV_EN
      BUSY: if (md_done) begin
        state_d = DONE;
        res_d   = md_res;
        ill_d   = 1'b0;
      end
`endif
      DONE:    if (ready_i) state_d = IDLE;
      default: ;
    endcase
    if (accept) begin
      if (fast_op) begin
        state_d = DONE;
        res_d   = fast_res;
        ill_d   = op_illegal;
      end else begin
        state_d = BUSY;
`ifdef ALU_MULDIV_EN
        md_start = 1'b1;
`endif
      end
    end
    if (kill_i) state_d = IDLE;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      res_q   <= '0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      ill_q   <= ill_d;
    end
  end

  assign valid_o      = (state_q == DONE);
  assign alu_result_o = res_q;
  assign illegal_o    = ill_q;

endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc: expectations queued at accept, compared when the result is taken.
module tb_alu_mc;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        valid_i, ready_o, kill_i, valid_o, ready_i, illegal_o;
  logic [31:0] op1_i, op2_i, alu_result_o;
  logic [5:0]  aluop_i;

  int n_cmp = 0;
  int n_err = 0;
  logic [32:0] sb[$];

`ifdef ALU_MULDIV_EN
  localparam int MD_LAT   = 33;
  localparam int MD_STALL = 32;
`else
  localparam int MD_LAT   = 1;
  localparam int MD_STALL = 0;
`endif

  alu_mc #(.XLEN(32), .AOPW(6)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .valid_i      (valid_i),
    .ready_o      (ready_o),
    .op1_i        (op1_i),
    .op2_i        (op2_i),
    .aluop_i      (aluop_i),
    .kill_i       (kill_i),
    .valid_o      (valid_o),
    .ready_i      (ready_i),
    .alu_result_o (alu_result_o),
    .illegal_o    (illegal_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference model: {illegal, result}
  function automatic logic [32:0] model(input int op, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sbv;
    logic [63:0] p;
    logic [31:0] r;
    logic        ill;
    logic        ovf;
    sa = a; sbv = b; p = '0; r = '0; ill = 1'b0;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      0: r = a + b;
      1: r = a << b[4:0];
      2: r = (sa < sbv) ? 32'd1 : 32'd0;
      3: r = (a < b) ? 32'd1 : 32'd0;
      4: r = a ^ b;
      5: r = a >> b[4:0];
      6: r = a | b;
      7: r = a & b;
      8: r = sa >>> b[4:0];
      9: r = a - b;
`ifdef ALU_MULDIV_EN
      10: begin p = {32'b0, a} * {32'b0, b}; r = p[31:0]; end
      11: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; r = p[63:32]; end
      12: begin p = {{32{a[31]}}, a} * {32'b0, b}; r = p[63:32]; end
      13: begin p = {32'b0, a} * {32'b0, b}; r = p[63:32]; end
      14: if (b == 0) r = 32'hFFFF_FFFF; else if (ovf) r = a; else r = sa / sbv;
      15: if (b == 0) r = 32'hFFFF_FFFF; else r = a / b;
      16: if (b == 0) r = a; else if (ovf) r = 32'd0; else r = sa % sbv;
      17: if (b == 0) r = a; else r = a % b;
`endif
      default: ill = 1'b1;
    endcase
    return {ill, r};
  endfunction

  always @(negedge clk_i) begin
    if (rst_ni && valid_o && ready_i) begin
      logic [32:0] exp_v;
      n_cmp++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_result: got ill=%0b res=%h, none expected", illegal_o, alu_result_o);
      end else begin
        exp_v = sb.pop_front();
        if ({illegal_o, alu_result_o} !== exp_v) begin
          n_err++;
          $display("FAIL result: got ill=%0b res=%h, expected ill=%0b res=%h",
                   illegal_o, alu_result_o, exp_v[32], exp_v[31:0]);
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 of the cycle after acceptance.
  task automatic drive_op(input int op, input logic [31:0] a, input logic [31:0] b);
    int guard = 0;
    valid_i = 1'b1; aluop_i = 6'(op); op1_i = a; op2_i = b;
    while (!ready_o && guard < 100) begin
      @(posedge clk_i); #1;
      guard++;
    end
    if (!ready_o) begin
      n_cmp++; n_err++;
      $display("FAIL accept_timeout: op=%0d ready_o never rose", op);
    end else begin
      sb.push_back(model(op, a, b));
    end
    @(posedge clk_i); #1;
    valid_i = 1'b0;
  endtask

  task automatic wait_result(input string name, input int exp_lat, input int exp_stall);
    int lat = 1;
    int stall = 0;
    while (!valid_o && lat < 200) begin
      if (!ready_o) stall++;
      @(posedge clk_i); #1;
      lat++;
    end
    n_cmp++;
    if (lat !== exp_lat) begin
      n_err++;
      $display("FAIL %s latency: got %0d, expected %0d", name, lat, exp_lat);
    end
    n_cmp++;
    if (stall !== exp_stall) begin
      n_err++;
      $display("FAIL %s stall: ready_o low %0d cycles, expected %0d", name, stall, exp_stall);
    end
  endtask

  task automatic run(input string name, input int op, input logic [31:0] a, input logic [31:0] b,
                     input int exp_lat, input int exp_stall);
    drive_op(op, a, b);
    wait_result(name, exp_lat, exp_stall);
    @(posedge clk_i); #1;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; valid_i = 1'b0; kill_i = 1'b0; ready_i = 1'b1;
    aluop_i = '0; op1_i = '0; op2_i = '0;
    repeat (2) @(posedge clk_i);
    #1;
    n_cmp++; if (valid_o !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b, expected 0", valid_o); end
    n_cmp++; if (alu_result_o !== 32'd0) begin n_err++; $display("FAIL reset_result: got %h, expected 0", alu_result_o); end
    n_cmp++; if (illegal_o !== 1'b0) begin n_err++; $display("FAIL reset_illegal: got %b, expected 0", illegal_o); end
    n_cmp++; if (ready_o !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b, expected 1", ready_o); end
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
  endtask

  task automatic test_back_to_back();
    int          ops[3] = '{0, 8, 2};
    logic [31:0] as[3]  = '{32'd5, 32'h8000_0000, 32'hFFFF_FFFF};
    logic [31:0] bs[3]  = '{32'd7, 32'd4, 32'd1};
    for (int i = 0; i < 3; i++) begin
      valid_i = 1'b1; aluop_i = 6'(ops[i]); op1_i = as[i]; op2_i = bs[i];
      n_cmp++;
      if (ready_o !== 1'b1) begin n_err++; $display("FAIL b2b_ready[%0d]: got %b, expected 1", i, ready_o); end
      sb.push_back(model(ops[i], as[i], bs[i]));
      @(posedge clk_i); #1;
      n_cmp++;
      if (valid_o !== 1'b1) begin n_err++; $display("FAIL b2b_valid[%0d]: got %b, expected 1", i, valid_o); end
    end
    valid_i = 1'b0;
    @(posedge clk_i); #1;
    n_cmp++;
    if (valid_o !== 1'b0) begin n_err++; $display("FAIL b2b_drain: valid_o %b, expected 0", valid_o); end
  endtask

  task automatic test_shift_mask();
    run("sll_mask", 1, 32'd1, 32'd33, 1, 0);
    run("srl_mask", 5, 32'h8000_0000, 32'd63, 1, 0);
  endtask

  task automatic test_illegal();
    run("illegal40", 40, 32'd123, 32'd456, 1, 0);
    run("illegal18", 18, 32'd9, 32'd9, 1, 0);
  endtask

  task automatic test_multiply();
    run("mulh",  11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MD_LAT, MD_STALL);
    run("mulhu", 13, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MD_LAT, MD_STALL);
    run("mul",   10, 32'd3, 32'hFFFF_FFFC, MD_LAT, MD_STALL);
    run("mulhsu", 12, 32'hFFFF_FFFE, 32'h8000_0000, MD_LAT, MD_STALL);
  endtask

  task automatic test_divide();
    run("div",       14, 32'hFFFF_FFF9, 32'd2, MD_LAT, MD_STALL);
    run("rem",       16, 32'hFFFF_FFF9, 32'd2, MD_LAT, MD_STALL);
    run("divu_zero", 15, 32'd7, 32'd0, 1, 0);
    run("remu_zero", 17, 32'd7, 32'd0, 1, 0);
    run("div_ovf",   14, 32'h8000_0000, 32'hFFFF_FFFF, 1, 0);
    run("rem_ovf",   16, 32'h8000_0000, 32'hFFFF_FFFF, 1, 0);
    run("divu_big",  15, 32'hFFFF_FFF0, 32'd3, MD_LAT, MD_STALL);
  endtask

  task automatic test_backpressure();
    ready_i = 1'b0;
    drive_op(0, 32'd100, 32'd23);
    valid_i = 1'b1; aluop_i = 6'd0; op1_i = 32'd1; op2_i = 32'd1;
    for (int k = 0; k < 5; k++) begin
      n_cmp++;
      if (valid_o !== 1'b1) begin n_err++; $display("FAIL bp_valid[%0d]: got %b, expected 1", k, valid_o); end
      n_cmp++;
      if (alu_result_o !== 32'd123) begin n_err++; $display("FAIL bp_result[%0d]: got %h, expected 7b", k, alu_result_o); end
      n_cmp++;
      if (ready_o !== 1'b0) begin n_err++; $display("FAIL bp_ready[%0d]: got %b, expected 0", k, ready_o); end
      @(posedge clk_i); #1;
    end
    valid_i = 1'b0;
    ready_i = 1'b1;
    @(posedge clk_i); #1;
    n_cmp++;
    if (valid_o !== 1'b0) begin n_err++; $display("FAIL bp_no_accept: valid_o %b, expected 0", valid_o); end
  endtask

  task automatic test_flush();
    int seen = 0;
    drive_op(14, 32'd100, 32'd7);
    repeat (9) @(posedge clk_i);
    #1;
    kill_i = 1'b1; ready_i = 1'b0;
    @(posedge clk_i); #1;
    kill_i = 1'b0;
    sb.delete();
    n_cmp++;
    if (valid_o !== 1'b0) begin n_err++; $display("FAIL kill_valid: got %b, expected 0", valid_o); end
    n_cmp++;
    if (ready_o !== 1'b1) begin n_err++; $display("FAIL kill_idle: ready_o %b, expected 1", ready_o); end
    // kill and valid together in IDLE: nothing accepted
    valid_i = 1'b1; kill_i = 1'b1; aluop_i = 6'd0; op1_i = 32'd1; op2_i = 32'd2;
    @(posedge clk_i); #1;
    valid_i = 1'b0; kill_i = 1'b0;
    n_cmp++;
    if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
      n_err++; $display("FAIL kill_wins: valid_o %b ready_o %b, expected 0 1", valid_o, ready_o);
    end
    ready_i = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (valid_o) seen++;
      @(posedge clk_i); #1;
    end
    n_cmp++;
    if (seen !== 0) begin n_err++; $display("FAIL kill_silent: valid_o high %0d cycles, expected 0", seen); end
    run("add_after_kill", 0, 32'd20, 32'd22, 1, 0);
  endtask

  task automatic test_reset_mid();
    drive_op(10, 32'd5, 32'd6);
    repeat (5) @(posedge clk_i);
    #1;
    rst_ni = 1'b0;
    #1;
    n_cmp++; if (valid_o !== 1'b0) begin n_err++; $display("FAIL rst_mid_valid: got %b, expected 0", valid_o); end
    n_cmp++; if (alu_result_o !== 32'd0) begin n_err++; $display("FAIL rst_mid_result: got %h, expected 0", alu_result_o); end
    n_cmp++; if (illegal_o !== 1'b0) begin n_err++; $display("FAIL rst_mid_illegal: got %b, expected 0", illegal_o); end
    n_cmp++; if (ready_o !== 1'b1) begin n_err++; $display("FAIL rst_mid_ready: got %b, expected 1", ready_o); end
    sb.delete();
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
    run("add_after_reset", 0, 32'd1, 32'd2, 1, 0);
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_shift_mask();
    test_illegal();
    test_multiply();
    test_divide();
    test_backpressure();
    test_flush();
    test_reset_mid();
    repeat (2) @(posedge clk_i);
    #1;
    n_cmp++;
    if (sb.size() !== 0) begin n_err++; $display("FAIL sb_drain: %0d results outstanding, expected 0", sb.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
